// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch stage and by decode.
package cpu_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory request/response, redirect input and decode output.
// Handshakes: a transfer happens in any cycle where valid && ready; the sender holds its payload
// stable while valid && !ready. Memory responses are never back-pressured.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            id_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous clear and occupancy count; push while full is
// accepted when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited in-order memory reads, buffers
// returned words with their PC and hands them to decode; redirects flush and refetch.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            req_fire, resp_live, resp_keep, pop, fifo_empty;
  fetch_entry_t    push_entry, head;

  // A request is only made when its response is guaranteed a buffer slot.
  assign credit_used        = {1'b0, outst_q} + {1'b0, fifo_count};
  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_addr      = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
  assign resp_live  = bus.imem_resp_valid && (outst_q != '0);
  assign resp_keep  = resp_live && (drop_q == '0) && !bus.redirect_valid;
  assign pop        = !fifo_empty && bus.id_ready && !bus.redirect_valid;
  assign push_entry = '{pc: resp_pc_q, instr: bus.imem_resp_data};

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    if (bus.redirect_valid) begin
      // Everything still in flight is stale; earlier drops are already part of outst_q.
      pc_d      = align_word(bus.redirect_pc);
      resp_pc_d = pc_d;
      outst_d   = outst_q - CW'(resp_live);
      drop_d    = outst_d;
    end else begin
      if (req_fire)  pc_d      = pc_q + 32'd4;
      if (resp_keep) resp_pc_d = resp_pc_q + 32'd4;
      outst_d = outst_q + CW'(req_fire) - CW'(resp_live);
      if (resp_live && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.redirect_valid),
    .push_i  (resp_keep),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.if_valid = !fifo_empty;
  assign bus.if_instr = fifo_empty ? NOP_INSTR : head.instr;
  assign bus.if_pc    = fifo_empty ? '0 : head.pc;
endmodule
